// File: rtl/dma_chan_regfile.sv
// AXI-Lite register file for an N-channel DMA controller: per-channel
// SRC/DST/LEN/CTRL/STATUS/BURST banks at CH_STRIDE plus a global IRQ summary.
module dma_chan_regfile #(
  parameter int          N_CH      = 4,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CH_STRIDE = 32'h20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [N_CH*32-1:0]  ch_src,
  output logic [N_CH*32-1:0]  ch_dst,
  output logic [N_CH*32-1:0]  ch_len,
  output logic [N_CH*2-1:0]   ch_burst,
  output logic [N_CH-1:0]     ch_start,
  input  logic [N_CH-1:0]     ch_busy,
  input  logic [N_CH-1:0]     ch_done,
  input  logic [N_CH-1:0]     ch_err,
  output logic                irq
);

  localparam int                SH       = $clog2(CH_STRIDE);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(CH_STRIDE - 32'd1);
  localparam logic [ADDR_W-1:0] IRQ_ADDR = ADDR_W'(32'h100);

  typedef struct packed {
    logic       ok;
    logic       glob;
    logic [2:0] ch;
    logic [2:0] sel;
  } dec_t;

  // Low two address bits are dropped; the global summary takes precedence over banks.
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word, bank, off;
    dec_t d;
    word = {addr[ADDR_W-1:2], 2'b00};
    bank = word >> SH;
    off  = (word & OFF_MASK) >> 2;
    d    = '0;
    if (word == IRQ_ADDR) begin
      d.ok   = 1'b1;
      d.glob = 1'b1;
    end else if (bank < ADDR_W'(N_CH) && off <= ADDR_W'(5)) begin
      d.ok  = 1'b1;
      d.ch  = bank[2:0];
      d.sel = off[2:0];
    end
    return d;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  logic [31:0]     src_reg [N_CH];
  logic [31:0]     dst_reg [N_CH];
  logic [31:0]     len_reg [N_CH];
  logic [1:0]      burst_reg [N_CH];
  logic [31:0]     src_nxt [N_CH];
  logic [31:0]     dst_nxt [N_CH];
  logic [31:0]     len_nxt [N_CH];
  logic [1:0]      burst_nxt [N_CH];
  logic [N_CH-1:0] irq_en_reg, done_reg, err_reg, start_reg;
  logic [N_CH-1:0] irq_en_nxt, done_nxt, err_nxt, start_nxt;
  logic [N_CH-1:0] clr_done, clr_err, set_err, pending;
  logic            wr_hs, wr_err, rd_hs, rd_err;
  logic [31:0]     rd_val;
  dec_t            wdec, rdec;

  assign wr_hs     = s_awvalid && s_wvalid && !s_bvalid;
  assign rd_hs     = s_arvalid && !s_rvalid;
  assign s_awready = rst_n && wr_hs;
  assign s_wready  = rst_n && wr_hs;
  assign s_arready = rst_n && rd_hs;
  assign wdec      = decode(s_awaddr);
  assign rdec      = decode(s_araddr);
  assign pending   = irq_en_reg & (done_reg | err_reg);
  assign ch_start  = start_reg;

  always_comb begin
    wr_err     = !wdec.ok;
    irq_en_nxt = irq_en_reg;
    start_nxt  = '0;
    clr_done   = '0;
    clr_err    = '0;
    set_err    = '0;
    for (int i = 0; i < N_CH; i++) begin
      src_nxt[i]   = src_reg[i];
      dst_nxt[i]   = dst_reg[i];
      len_nxt[i]   = len_reg[i];
      burst_nxt[i] = burst_reg[i];
      if (wr_hs && wdec.ok && !wdec.glob && wdec.ch == 3'(i)) begin
        case (wdec.sel)
          3'd0: if (ch_busy[i]) wr_err = 1'b1;
                else src_nxt[i] = merge_bytes(src_reg[i], s_wdata, s_wstrb);
          3'd1: if (ch_busy[i]) wr_err = 1'b1;
                else dst_nxt[i] = merge_bytes(dst_reg[i], s_wdata, s_wstrb);
          3'd2: if (ch_busy[i]) wr_err = 1'b1;
                else len_nxt[i] = merge_bytes(len_reg[i], s_wdata, s_wstrb);
          3'd3: if (s_wstrb[0]) begin
                  if (s_wdata[0] && ch_busy[i]) wr_err = 1'b1;
                  else begin
                    irq_en_nxt[i] = s_wdata[1];
                    if (s_wdata[0]) begin
                      // A bad configuration is reported through ERR, not the bus response.
                      if (len_reg[i] == '0 || burst_reg[i] == 2'b11) set_err[i] = 1'b1;
                      else begin
                        start_nxt[i] = 1'b1;
                        clr_done[i]  = 1'b1;
                        clr_err[i]   = 1'b1;
                      end
                    end
                  end
                end
          3'd4: if (s_wstrb[0]) begin
                  clr_done[i] = s_wdata[0];
                  clr_err[i]  = s_wdata[1];
                end
          3'd5: if (ch_busy[i]) wr_err = 1'b1;
                else if (s_wstrb[0]) burst_nxt[i] = s_wdata[1:0];
          default: ;
        endcase
      end
    end
    // Engine events are ORed in last so they win over a same-cycle clear.
    done_nxt = (done_reg & ~clr_done) | ch_done;
    err_nxt  = (err_reg & ~clr_err) | set_err | ch_err;
  end

  always_comb begin
    rd_val = '0;
    rd_err = !rdec.ok;
    if (rdec.glob) rd_val = 32'(pending);
    else begin
      for (int i = 0; i < N_CH; i++) begin
        if (rdec.ok && rdec.ch == 3'(i)) begin
          case (rdec.sel)
            3'd0: rd_val = src_reg[i];
            3'd1: rd_val = dst_reg[i];
            3'd2: rd_val = len_reg[i];
            3'd3: rd_val = {30'b0, irq_en_reg[i], 1'b0};
            3'd4: rd_val = {29'b0, ch_busy[i], err_reg[i], done_reg[i]};
            3'd5: rd_val = {30'b0, burst_reg[i]};
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        src_reg[i]   <= '0;
        dst_reg[i]   <= '0;
        len_reg[i]   <= '0;
        burst_reg[i] <= 2'b01;
      end
      irq_en_reg <= '0;
      done_reg   <= '0;
      err_reg    <= '0;
      start_reg  <= '0;
      irq        <= 1'b0;
      s_bvalid   <= 1'b0;
      s_bresp    <= 2'b00;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        src_reg[i]   <= src_nxt[i];
        dst_reg[i]   <= dst_nxt[i];
        len_reg[i]   <= len_nxt[i];
        burst_reg[i] <= burst_nxt[i];
      end
      irq_en_reg <= irq_en_nxt;
      done_reg   <= done_nxt;
      err_reg    <= err_nxt;
      start_reg  <= start_nxt;
      irq        <= |pending;
      if (wr_hs) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= 2'b00;
    end else if (rd_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_val;
      s_rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign ch_src[32*g +: 32]  = src_reg[g];
    assign ch_dst[32*g +: 32]  = dst_reg[g];
    assign ch_len[32*g +: 32]  = len_reg[g];
    assign ch_burst[2*g +: 2]  = burst_reg[g];
  end

endmodule

// File: tb/tb_dma_chan_regfile.sv
// Bench for dma_chan_regfile: directed scenarios plus randomized register traffic
// checked against an address-map model of the channel banks.
module tb_dma_chan_regfile;
  localparam int N_CH = 4;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic [N_CH*32-1:0] ch_src, ch_dst, ch_len;
  logic [N_CH*2-1:0] ch_burst;
  logic [N_CH-1:0] ch_start, ch_busy, ch_done, ch_err;
  logic irq;

  always #5 clk = ~clk;

  dma_chan_regfile #(.N_CH(N_CH), .ADDR_W(ADDR_W), .CH_STRIDE(32'h20)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len), .ch_burst(ch_burst),
    .ch_start(ch_start), .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err),
    .irq(irq)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model of the register map
  logic [31:0] m_src [4];
  logic [31:0] m_dst [4];
  logic [31:0] m_len [4];
  logic [1:0]  m_burst [4];
  logic [3:0]  m_ien, m_done, m_err;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_burst[c] = 2'b01;
    end
    m_ien = 0; m_done = 0; m_err = 0;
  endtask

  function automatic logic [3:0] m_pending();
    return m_ien & (m_done | m_err);
  endfunction

  task automatic model_write(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] st,
                             input logic [3:0] busy, output logic [1:0] resp, output logic [3:0] start);
    int a, bank, off;
    logic [31:0] mask;
    a = int'(addr) & ~3;
    bank = a / 32;
    off = a % 32;
    resp = 2'b00;
    start = 4'b0;
    if (a == 256) return;
    if (bank >= 4 || off > 20) begin resp = 2'b10; return; end
    case (off)
      0, 4, 8: begin
        if (busy[bank]) resp = 2'b10;
        else for (int b = 0; b < 4; b++) if (st[b]) begin
          mask = 32'hFF << (8 * b);
          if (off == 0) m_src[bank] = (m_src[bank] & ~mask) | (d & mask);
          else if (off == 4) m_dst[bank] = (m_dst[bank] & ~mask) | (d & mask);
          else m_len[bank] = (m_len[bank] & ~mask) | (d & mask);
        end
      end
      12: if (st[0]) begin
        if (d[0] && busy[bank]) resp = 2'b10;
        else begin
          m_ien[bank] = d[1];
          if (d[0]) begin
            if (m_len[bank] == 0 || m_burst[bank] == 2'b11) m_err[bank] = 1'b1;
            else begin start[bank] = 1'b1; m_done[bank] = 1'b0; m_err[bank] = 1'b0; end
          end
        end
      end
      16: if (st[0]) begin
        if (d[0]) m_done[bank] = 1'b0;
        if (d[1]) m_err[bank] = 1'b0;
      end
      default: begin
        if (busy[bank]) resp = 2'b10;
        else if (st[0]) m_burst[bank] = d[1:0];
      end
    endcase
  endtask

  task automatic model_read(input logic [11:0] addr, input logic [3:0] busy,
                            output logic [31:0] d, output logic [1:0] resp);
    int a, bank, off;
    a = int'(addr) & ~3;
    bank = a / 32;
    off = a % 32;
    d = 0;
    resp = 2'b00;
    if (a == 256) begin d = {28'b0, m_pending()}; return; end
    if (bank >= 4 || off > 20) begin resp = 2'b10; return; end
    case (off)
      0: d = m_src[bank];
      4: d = m_dst[bank];
      8: d = m_len[bank];
      12: d = {30'b0, m_ien[bank], 1'b0};
      16: d = {29'b0, busy[bank], m_err[bank], m_done[bank]};
      default: d = {30'b0, m_burst[bank]};
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0;
    ch_busy = 0; ch_done = 0; ch_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Bus drivers: s0 is ch_start right after the handshake edge, s1 one cycle later.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output logic [3:0] s0, output logic [3:0] s1);
    int t = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    #1;
    while (!(s_awready && s_wready) && t < 20) begin @(posedge clk); #2; t++; end
    if (t >= 20) begin n_checks++; $display("FAIL wr_timeout addr=%h", a); end
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
    s0 = ch_start;
    resp = s_bresp;
    if (!s_bvalid) begin n_checks++; $display("FAIL wr_no_bvalid addr=%h got=0 exp=1", a); end
    @(posedge clk); #1;
    s1 = ch_start;
    s_bready = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t = 0;
    s_araddr = a; s_arvalid = 1; s_rready = 1;
    #1;
    while (!s_arready && t < 20) begin @(posedge clk); #2; t++; end
    if (t >= 20) begin n_checks++; $display("FAIL rd_timeout addr=%h", a); end
    @(posedge clk); #1;
    s_arvalid = 0;
    if (!s_rvalid) begin n_checks++; $display("FAIL rd_no_rvalid addr=%h got=0 exp=1", a); end
    d = s_rdata;
    resp = s_rresp;
    @(posedge clk); #1;
    s_rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0] r;
    int exp_tab[6] = '{0, 0, 0, 0, 0, 1};
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, irq} !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, irq}); else n_pass++;
    n_checks++; if ({s_rdata, s_bresp, s_rresp} !== 36'h0)
      $display("FAIL reset_data got=%h exp=0", {s_rdata, s_bresp, s_rresp}); else n_pass++;
    n_checks++; if (ch_start !== 4'b0 || ch_burst !== 8'h55 || ch_src !== '0)
      $display("FAIL reset_ch got=%b/%h exp=0000/55", ch_start, ch_burst); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 6; k++) begin
        axi_read(12'(c * 32 + k * 4), d, r);
        n_checks++; if (d !== 32'(exp_tab[k]) || r !== 2'b00)
          $display("FAIL reset_rd_c%0d_r%0d got=%h/%b exp=%h/00", c, k, d, r, exp_tab[k]); else n_pass++;
      end
    axi_read(12'h100, d, r);
    n_checks++; if (d !== 0 || r !== 2'b00) $display("FAIL reset_irq_stat got=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] d, ed;
    logic [3:0] st, busy, es, s0, s1;
    logic [1:0] r, er;
    int sel;
    for (int k = 0; k < 80; k++) begin
      busy = 4'($urandom);
      ch_busy = busy;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = 12'($urandom);
      else if (sel == 1) a = 12'h100 | 12'($urandom_range(0, 3));
      else a = 12'($urandom_range(0, 7) * 32 + $urandom_range(0, 7) * 4 + (sel == 2 ? $urandom_range(0, 3) : 0));
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d & 32'h3;
      st = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        model_write(a, d, st, busy, er, es);
        axi_write(a, d, st, r, s0, s1);
        n_checks++; if (r !== er) $display("FAIL rand_wr_resp addr=%h got=%b exp=%b", a, r, er); else n_pass++;
        n_checks++; if (s0 !== es || s1 !== 4'b0)
          $display("FAIL rand_wr_start addr=%h got=%b,%b exp=%b,0000", a, s0, s1, es); else n_pass++;
      end else begin
        model_read(a, busy, ed, er);
        axi_read(a, d, r);
        n_checks++; if (d !== ed || r !== er)
          $display("FAIL rand_rd addr=%h got=%h/%b exp=%h/%b", a, d, r, ed, er); else n_pass++;
      end
    end
    ch_busy = 0;
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (ch_src[32*c +: 32] !== m_src[c] || ch_dst[32*c +: 32] !== m_dst[c] ||
                      ch_len[32*c +: 32] !== m_len[c] || ch_burst[2*c +: 2] !== m_burst[c])
        $display("FAIL rand_outputs_c%0d got=%h %h %h %b exp=%h %h %h %b", c, ch_src[32*c +: 32],
                 ch_dst[32*c +: 32], ch_len[32*c +: 32], ch_burst[2*c +: 2], m_src[c], m_dst[c], m_len[c], m_burst[c]);
      else n_pass++;
    end
    n_checks++; if (irq !== |m_pending()) $display("FAIL rand_irq got=%b exp=%b", irq, |m_pending()); else n_pass++;
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0] r;
    logic [3:0] s0, s1;
    axi_write(12'h040, 32'hDEADBEEF, 4'b0101, r, s0, s1);
    n_checks++; if (r !== 2'b00) $display("FAIL strobe_resp got=%b exp=00", r); else n_pass++;
    axi_read(12'h040, d, r);
    n_checks++; if (d !== 32'h00AD00EF) $display("FAIL strobe_rd got=%h exp=00ad00ef", d); else n_pass++;
    n_checks++; if (ch_src[95:64] !== 32'h00AD00EF) $display("FAIL strobe_port got=%h exp=00ad00ef", ch_src[95:64]); else n_pass++;
  endtask

  task automatic test_start_done();
    logic [31:0] d;
    logic [1:0] r;
    logic [3:0] s0, s1;
    axi_write(12'h028, 32'h40, 4'hF, r, s0, s1);
    axi_write(12'h034, 32'h1, 4'hF, r, s0, s1);
    axi_write(12'h02C, 32'h3, 4'hF, r, s0, s1);
    n_checks++; if (r !== 2'b00) $display("FAIL start_resp got=%b exp=00", r); else n_pass++;
    n_checks++; if (s0 !== 4'b0010 || s1 !== 4'b0000)
      $display("FAIL start_pulse got=%b,%b exp=0010,0000", s0, s1); else n_pass++;
    ch_done = 4'b0010;
    tick();
    ch_done = 4'b0000;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_latency got=%b exp=0", irq); else n_pass++;
    tick();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else n_pass++;
    axi_read(12'h030, d, r);
    n_checks++; if (d !== 32'h1) $display("FAIL done_status got=%h exp=1", d); else n_pass++;
    axi_read(12'h100, d, r);
    n_checks++; if (d !== 32'h2) $display("FAIL irq_stat got=%h exp=2", d); else n_pass++;
    axi_write(12'h030, 32'h1, 4'hF, r, s0, s1);
    tick();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else n_pass++;
  endtask

  task automatic test_cfg_err();
    logic [31:0] d;
    logic [1:0] r;
    logic [3:0] s0, s1;
    axi_write(12'h008, 32'h0, 4'hF, r, s0, s1);
    axi_write(12'h00C, 32'h1, 4'hF, r, s0, s1);
    n_checks++; if ((s0 | s1) !== 4'b0 || r !== 2'b00)
      $display("FAIL cfg_len0_nopulse got=%b/%b exp=0000/00", s0 | s1, r); else n_pass++;
    axi_read(12'h010, d, r);
    n_checks++; if (d !== 32'h2) $display("FAIL cfg_len0_err got=%h exp=2", d); else n_pass++;
    axi_write(12'h010, 32'h2, 4'hF, r, s0, s1);
    axi_read(12'h010, d, r);
    n_checks++; if (d !== 32'h0) $display("FAIL cfg_w1c_err got=%h exp=0", d); else n_pass++;
    axi_write(12'h014, 32'h3, 4'hF, r, s0, s1);
    axi_write(12'h008, 32'h4, 4'hF, r, s0, s1);
    axi_write(12'h00C, 32'h1, 4'hF, r, s0, s1);
    n_checks++; if ((s0 | s1) !== 4'b0) $display("FAIL cfg_burst3_nopulse got=%b exp=0000", s0 | s1); else n_pass++;
    axi_read(12'h010, d, r);
    n_checks++; if (d !== 32'h2) $display("FAIL cfg_burst3_err got=%h exp=2", d); else n_pass++;
  endtask

  task automatic test_busy();
    logic [31:0] d;
    logic [1:0] r;
    logic [3:0] s0, s1;
    ch_busy = 4'b1000;
    axi_write(12'h064, 32'h1234, 4'hF, r, s0, s1);
    n_checks++; if (r !== 2'b10) $display("FAIL busy_dst_slverr got=%b exp=10", r); else n_pass++;
    axi_read(12'h064, d, r);
    n_checks++; if (d !== 32'h0) $display("FAIL busy_dst_unchanged got=%h exp=0", d); else n_pass++;
    axi_write(12'h06C, 32'h3, 4'hF, r, s0, s1);
    n_checks++; if (r !== 2'b10 || (s0 | s1) !== 4'b0)
      $display("FAIL busy_start_blocked got=%b/%b exp=10/0000", r, s0 | s1); else n_pass++;
    axi_write(12'h06C, 32'h2, 4'hF, r, s0, s1);
    n_checks++; if (r !== 2'b00) $display("FAIL busy_irqen_ok got=%b exp=00", r); else n_pass++;
    ch_done = 4'b1000;
    tick();
    ch_done = 4'b0000;
    // W1C on DONE lands in the same cycle as another done pulse
    s_awaddr = 12'h070; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    ch_done = 4'b1000;
    #1;
    n_checks++; if (s_awready !== 1'b1) $display("FAIL race_ready got=%b exp=1", s_awready); else n_pass++;
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; ch_done = 4'b0000;
    tick();
    s_bready = 0;
    axi_read(12'h070, d, r);
    n_checks++; if (d !== 32'h5) $display("FAIL race_done_kept got=%h exp=5", d); else n_pass++;
    n_checks++; if (irq !== 1'b1) $display("FAIL busy_irq got=%b exp=1", irq); else n_pass++;
    ch_busy = 4'b0000;
  endtask

  task automatic test_decode_err();
    logic [31:0] d;
    logic [1:0] r;
    logic [3:0] s0, s1;
    axi_read(12'h0FC, d, r);
    n_checks++; if (d !== 32'h0 || r !== 2'b10) $display("FAIL bad_bank_rd got=%h/%b exp=0/10", d, r); else n_pass++;
    axi_read(12'h078, d, r);
    n_checks++; if (r !== 2'b10) $display("FAIL bad_off_rd got=%b exp=10", r); else n_pass++;
    axi_write(12'h078, 32'hFFFF_FFFF, 4'hF, r, s0, s1);
    n_checks++; if (r !== 2'b10) $display("FAIL bad_off_wr got=%b exp=10", r); else n_pass++;
    axi_read(12'h02A, d, r);
    n_checks++; if (d !== 32'h40 || r !== 2'b00) $display("FAIL misaligned_rd got=%h/%b exp=40/00", d, r); else n_pass++;
  endtask

  task automatic test_bready_hold();
    logic [31:0] d;
    logic [1:0] r;
    int t = 0;
    s_awaddr = 12'h000; s_wdata = 32'h11111111; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 0;
    #1;
    while (!s_awready && t < 20) begin @(posedge clk); #2; t++; end
    if (t >= 20) begin n_checks++; $display("FAIL hold_timeout got=0 exp=1"); end
    @(posedge clk); #1;
    s_wdata = 32'h22222222;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (s_bvalid !== 1'b1 || s_awready !== 1'b0)
        $display("FAIL bvalid_hold_%0d got=%b/%b exp=1/0", k, s_bvalid, s_awready); else n_pass++;
      tick();
    end
    s_awvalid = 0; s_wvalid = 0; s_bready = 1;
    tick();
    s_bready = 0;
    n_checks++; if (s_bvalid !== 1'b0) $display("FAIL bvalid_release got=%b exp=0", s_bvalid); else n_pass++;
    axi_read(12'h000, d, r);
    n_checks++; if (d !== 32'h11111111) $display("FAIL hold_single_write got=%h exp=11111111", d); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [1:0] r;
    s_awaddr = 12'h044; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    s_araddr = 12'h044; s_arvalid = 1; s_rready = 1;
    #1;
    n_checks++; if (!(s_awready && s_arready)) $display("FAIL sim_ready got=%b%b exp=11", s_awready, s_arready); else n_pass++;
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    n_checks++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h0)
      $display("FAIL sim_pre_write got=%b/%h exp=1/0", s_rvalid, s_rdata); else n_pass++;
    tick();
    s_bready = 0; s_rready = 0;
    axi_read(12'h044, d, r);
    n_checks++; if (d !== 32'hCAFEF00D) $display("FAIL sim_post_write got=%h exp=cafef00d", d); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int t = 0;
    s_araddr = 12'h028; s_arvalid = 1; s_rready = 0;
    #1;
    while (!s_arready && t < 20) begin @(posedge clk); #2; t++; end
    if (t >= 20) begin n_checks++; $display("FAIL midrd_timeout got=0 exp=1"); end
    @(posedge clk); #1;
    s_arvalid = 0;
    n_checks++; if (s_rvalid !== 1'b1) $display("FAIL midrd_valid got=%b exp=1", s_rvalid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (s_rvalid !== 1'b0 || s_rdata !== 32'h0)
      $display("FAIL midrd_reset got=%b/%h exp=0/0", s_rvalid, s_rdata); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_random();
    do_reset();
    test_strobe();
    test_start_done();
    test_cfg_err();
    test_busy();
    test_decode_err();
    test_bready_hold();
    test_simultaneous();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_chan_regfile.md
Name: dma_chan_regfile

Overview:
Parametrised AXI-Lite register file for an N-channel DMA controller. It generalises the single-channel SRC/DST/LENGTH/CONTROL/STATUS/BURST map into per-channel register banks at a fixed stride, plus a global interrupt summary register. Additional behaviour:
- Self-clearing start pulses.
- W1C status bits.
- Busy-channel write protection.
- Start-time configuration checks.
- Byte strobes.
- Aggregated IRQ.

It sits between the AXI-Lite interconnect and the DMA channel engines.

Parameters:
N_CH, 4, number of DMA channels (1..8)
ADDR_W, 12, AXI-Lite address width (>= 9)
CH_STRIDE, 32'h20, byte stride between channel banks (power of two, >= 32'h20)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_W  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_W  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read valid
s_rready  in  1  read ready
ch_src  out  N_CH*32  per-channel source address (channel i at [32i+:32])
ch_dst  out  N_CH*32  per-channel destination address
ch_len  out  N_CH*32  per-channel byte length
ch_burst  out  N_CH*2  per-channel burst type
ch_start  out  N_CH  one-cycle start pulse per channel
ch_busy  in  N_CH  engine busy
ch_done  in  N_CH  engine completion pulse
ch_err  in  N_CH  engine error pulse
irq  out  1  aggregated interrupt

Behaviour:
- Address map:
  - Channel i bank base = i*CH_STRIDE.
  - Offsets: SRC 0x00 (RW), DST 0x04 (RW), LEN 0x08 (RW), CTRL 0x0C (bit0 START write-only, reads 0; bit1 IRQ_EN RW), STATUS 0x10 (bit0 DONE, bit1 ERR, W1C; bit2 BUSY, RO mirror of ch_busy), BURST 0x14 (RW, bits[1:0], reset 2'b01 INCR).
  - Global IRQ_STAT at 0x100: RO, bit i = channel i pending interrupt.
  - Channel bank index ≥ N_CH, in-bank offset > 0x14, or any other address: SLVERR, read data 0, no state change.
- Address decode: only addr[1:0]==0 is decoded; misaligned address bits are ignored (truncated).
- Reset:
  - All data registers, IRQ_EN, DONE, ERR = 0; BURST = 2'b01.
  - ch_start = 0, irq = 0.
  - All valid/ready outputs = 0, resp = 00, rdata = 0.
  - Reset mid-transaction drops any outstanding response.
- Write channel:
  - s_awready and s_wready assert together for one cycle only when s_awvalid && s_wvalid && !s_bvalid.
  - The register update happens on that handshake cycle. s_bvalid asserts the next cycle and holds until s_bready.
  - One write is outstanding at a time. AW without W (or W without AW) waits.
- Read channel:
  - s_arready asserts for one cycle when s_arvalid && !s_rvalid.
  - s_rdata/s_rresp are registered and valid the next cycle; they hold until s_rready.
  - One read is outstanding at a time.
- Byte strobes: honoured per byte on SRC/DST/LEN. CTRL, STATUS and BURST act only if wstrb[0]=1.
- Busy protection: while ch_busy[i]=1, writes to SRC/DST/LEN/BURST and CTRL with START=1 return SLVERR and change nothing. IRQ_EN-only CTRL writes and STATUS W1C are allowed.
- START (CTRL write with bit0=1, channel idle):
  - If LEN==0 or BURST==2'b11: no pulse, ERR set, response OKAY.
  - Otherwise: ch_start[i]=1 for exactly the cycle after the handshake, and DONE/ERR for that channel clear.
- Status bits:
  - DONE sets on ch_done[i]; ERR sets on ch_err[i].
  - A set event in the same cycle as a W1C clear wins (bit ends 1).
- IRQ: per-channel pending = IRQ_EN & (DONE | ERR); irq = OR over channels, registered (one-cycle latency from the status bit).
- Simultaneous read and write to the same register: the read returns the pre-write value.

Test Plan:
- Reset, then read each channel's SRC/DST/LEN/BURST/CTRL/STATUS -> 0,0,0,0x1,0,0 with OKAY; IRQ_STAT=0; irq=0.
- Write ch2 SRC=0xDEADBEEF with wstrb=4'b0101 -> readback 0x00AD00EF; ch_src[95:64]=0x00AD00EF.
- ch1: LEN=0x40, BURST=1, CTRL=0x3 -> ch_start[1] high exactly one cycle. Then ch_done[1] pulse -> STATUS=0x1, IRQ_STAT=0x2, irq=1 one cycle later. Write STATUS=0x1 -> irq=0.
- ch0: LEN=0, CTRL=0x1 -> no ch_start, STATUS.ERR=1. Then BURST=3, LEN=4, CTRL=0x1 -> no pulse, ERR=1.
- Hold ch_busy[3]=1; write DST=0x1234 -> SLVERR, DST unchanged. Drive W1C on DONE in the same cycle as a ch_done[3] pulse -> DONE stays 1.
- Read 0x0FC (N_CH=4, bank 7) -> SLVERR, rdata 0. Hold s_bready=0 for 5 cycles -> bvalid held, no further AW/W accepted. Assert rst_n low mid-read -> rvalid drops to 0 immediately.
